light_cmd_encoder: RTL and testbench
====================================

LIGHT_CMD_ENCODER -- requirements
Module: light_cmd_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized samples needed to accept a button level (range 1..255).
REQ-002 SHALL have parameter FLASH_HALF_PERIOD, default 8, clk cycles per flash high or low phase (range 1..65535).
REQ-003 SHALL have parameter AUTO_CANCEL_FLASHES, default 3, complete flash periods before a turn indicator self-cancels (used only under REQ-030).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port btn_left, input, 1, raw left-stalk contact, asynchronous, active-high.
REQ-007 SHALL have port btn_right, input, 1, raw right-stalk contact, asynchronous, active-high.
REQ-008 SHALL have port btn_hazard, input, 1, raw hazard pushbutton, asynchronous, active-high.
REQ-009 SHALL have port btn_int, input, 1, raw interior-mode pushbutton, asynchronous, active-high.
REQ-010 SHALL have port select_ext, output, [0:1], exterior command: 00 off, 01 right, 10 left, 11 breakdown.
REQ-011 SHALL have port select_int, output, [0:1], interior command: 00 on, 01 door, 10 off; 11 never driven.
REQ-012 SHALL have port flash, output, 1, blink clock for the exterior light stage.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer, then a debouncer whose accepted level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples differing from the current accepted level.
REQ-014 SHALL generate a one-cycle press event on each 0->1 transition of an accepted level; releases generate no event.
REQ-015 SHALL implement exterior FSM states OFF, LEFT, RIGHT, HAZARD, registered, driving select_ext as 00, 10, 01, 11 respectively.
REQ-016 SHALL on hazard press: from OFF/LEFT/RIGHT go to HAZARD; from HAZARD go to OFF.
REQ-017 SHALL on left press: OFF->LEFT, LEFT->OFF, RIGHT->LEFT, HAZARD unchanged; right press symmetric.
REQ-018 SHALL in one cycle apply priority hazard > left/right; simultaneous left and right press without hazard is ignored.
REQ-019 SHALL update select_ext on the clock edge following the press event, i.e. DEBOUNCE_CYCLES+3 edges after a clean raw transition.
REQ-020 SHALL hold flash at 0 in OFF.
REQ-021 SHALL on any transition out of OFF set flash to 1 and clear the phase counter, then toggle flash every FLASH_HALF_PERIOD cycles.
REQ-022 SHALL keep flash phase continuous across LEFT/RIGHT/HAZARD transitions among themselves.
REQ-023 SHALL implement interior modes DOOR, ON, OFF; btn_int press cycles DOOR->ON->OFF->DOOR; select_int updates on the edge after the event.
REQ-024 SHALL size the phase counter to exactly $clog2(FLASH_HALF_PERIOD) bits (min 1), with wrap to 0 at FLASH_HALF_PERIOD-1.

Reset
REQ-025 SHALL on rst_n low, asynchronously: select_ext=00, select_int=01, flash=0, FSMs to OFF/DOOR, counters and synchronizers 0, accepted levels 0.
REQ-026 SHALL release synchronously; reset asserted mid-flash or mid-debounce discards all progress.
REQ-027 SHALL treat a button held through reset release as one press after DEBOUNCE_CYCLES+2 edges.

Configuration
REQ-028 SHALL use macro LIGHT_CMD_AUTO_CANCEL_EN.
REQ-029 SHALL without the macro keep LEFT/RIGHT until an explicit press.
REQ-030 SHALL with the macro return LEFT/RIGHT to OFF on the flash 1->0 edge completing AUTO_CANCEL_FLASHES periods since entering the state; HAZARD unaffected; a press in the same cycle takes precedence over cancel.

Structure
REQ-031 SHALL place exterior and interior select encodings and FSM state enums in shared package light_ctrl_pkg.
REQ-032 SHALL implement synchronizer+debouncer+edge detect as sub-module btn_debounce, instantiated four times.

Verification
REQ-033 Reset, left held 6 clean cycles (defaults) -> select_ext 00 then 10 at edge 7 after rise; flash 1 for 8 cycles, 0 for 8.
REQ-034 Left bouncing 1-0-1 every cycle for 20 cycles, then released -> no event, select_ext stays 00.
REQ-035 LEFT active, hazard press -> 11, flash phase unbroken; hazard press again -> 00, flash 0 next cycle.
REQ-036 Left and right pressed same cycle from OFF -> select_ext stays 00; btn_int pressed 3 times -> select_int 00, 10, 01.
REQ-037 With LIGHT_CMD_AUTO_CANCEL_EN: right press -> 01, back to 00 exactly 48 cycles after entry; without it -> 01 held 500 cycles.
REQ-038 rst_n pulsed low mid-HAZARD -> outputs 00/01/0 immediately, no events within 5 cycles of release.

Source files
------------

// File: rtl/light_ctrl_pkg.sv
// rtl/light_ctrl_pkg.sv - shared select encodings, FSM state enums and sizing helper for the light command encoder
package light_ctrl_pkg;

    localparam logic [1:0] SEL_EXT_OFF    = 2'b00;
    localparam logic [1:0] SEL_EXT_RIGHT  = 2'b01;
    localparam logic [1:0] SEL_EXT_LEFT   = 2'b10;
    localparam logic [1:0] SEL_EXT_HAZARD = 2'b11;

    localparam logic [1:0] SEL_INT_ON   = 2'b00;
    localparam logic [1:0] SEL_INT_DOOR = 2'b01;
    localparam logic [1:0] SEL_INT_OFF  = 2'b10;

    typedef enum logic [1:0] {
        EXT_OFF    = 2'd0,
        EXT_LEFT   = 2'd1,
        EXT_RIGHT  = 2'd2,
        EXT_HAZARD = 2'd3
    } ext_state_e;

    typedef enum logic [1:0] {
        INT_DOOR = 2'd0,
        INT_ON   = 2'd1,
        INT_OFF  = 2'd2
    } int_state_e;

    // Counter width holding 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [1:0] ext_select(input ext_state_e s);
        case (s)
            EXT_LEFT:   return SEL_EXT_LEFT;
            EXT_RIGHT:  return SEL_EXT_RIGHT;
            EXT_HAZARD: return SEL_EXT_HAZARD;
            default:    return SEL_EXT_OFF;
        endcase
    endfunction

    function automatic logic [1:0] int_select(input int_state_e s);
        case (s)
            INT_ON:  return SEL_INT_ON;
            INT_OFF: return SEL_INT_OFF;
            default: return SEL_INT_DOOR;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, counting debouncer and press (rising-edge) detector for one raw button
module btn_debounce
    import light_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic press_o
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_prev_q;

    // Any sample equal to the accepted level restarts the stability count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], btn_raw_i};
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/light_cmd_encoder.sv
// rtl/light_cmd_encoder.sv - turn/hazard/interior light command encoder; LIGHT_CMD_AUTO_CANCEL_EN enables turn self-cancel
module light_cmd_encoder
    import light_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES     = 4,
    parameter int unsigned FLASH_HALF_PERIOD   = 8,
    parameter int unsigned AUTO_CANCEL_FLASHES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_hazard,
    input  logic       btn_int,
    output logic [0:1] select_ext,
    output logic [0:1] select_int,
    output logic       flash
);

    localparam int unsigned PW = cnt_width(FLASH_HALF_PERIOD);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || FLASH_HALF_PERIOD < 1 ||
        FLASH_HALF_PERIOD > 65535 || AUTO_CANCEL_FLASHES < 1) begin : g_bad_params
        $error("light_cmd_encoder: parameter out of range");
    end

    logic press_l, press_r, press_h, press_i;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk(clk), .rst_n(rst_n), .btn_raw_i(btn_left), .press_o(press_l));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk(clk), .rst_n(rst_n), .btn_raw_i(btn_right), .press_o(press_r));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hazard (
        .clk(clk), .rst_n(rst_n), .btn_raw_i(btn_hazard), .press_o(press_h));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_int (
        .clk(clk), .rst_n(rst_n), .btn_raw_i(btn_int), .press_o(press_i));

    ext_state_e    ext_q, ext_d, ext_press;
    int_state_e    int_q, int_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          flash_q, flash_d;
    logic          phase_wrap;

    // Hazard wins; left and right together cancel each other out.
    always_comb begin
        ext_press = ext_q;
        if (press_h) begin
            ext_press = (ext_q == EXT_HAZARD) ? EXT_OFF : EXT_HAZARD;
        end else if (press_l && !press_r) begin
            case (ext_q)
                EXT_OFF, EXT_RIGHT: ext_press = EXT_LEFT;
                EXT_LEFT:           ext_press = EXT_OFF;
                default:            ext_press = ext_q;
            endcase
        end else if (press_r && !press_l) begin
            case (ext_q)
                EXT_OFF, EXT_LEFT: ext_press = EXT_RIGHT;
                EXT_RIGHT:         ext_press = EXT_OFF;
                default:           ext_press = ext_q;
            endcase
        end
    end

    assign phase_wrap = (phase_q == PW'(FLASH_HALF_PERIOD - 1));

`ifdef LIGHT_CMD_AUTO_CANCEL_EN
    localparam int unsigned CW = cnt_width(AUTO_CANCEL_FLASHES);

    logic [CW-1:0] periods_q, periods_d;
    logic          period_done, cancel;

    // A full period ends where the low phase wraps back to high.
    assign period_done = (ext_q != EXT_OFF) && phase_wrap && !flash_q;
    assign cancel      = (ext_q == EXT_LEFT || ext_q == EXT_RIGHT) && period_done &&
                         (periods_q == CW'(AUTO_CANCEL_FLASHES - 1)) && (ext_press == ext_q);

    always_comb begin
        ext_d     = cancel ? EXT_OFF : ext_press;
        periods_d = periods_q;
        if (ext_d != ext_q) begin
            periods_d = '0;
        end else if (period_done) begin
            periods_d = periods_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            periods_q <= '0;
        end else begin
            periods_q <= periods_d;
        end
    end
`else
    assign ext_d = ext_press;
`endif

    // Phase restarts only when leaving OFF, so indicator-to-hazard swaps keep rhythm.
    always_comb begin
        phase_d = phase_q;
        flash_d = flash_q;
        if (ext_d == EXT_OFF) begin
            phase_d = '0;
            flash_d = 1'b0;
        end else if (ext_q == EXT_OFF) begin
            phase_d = '0;
            flash_d = 1'b1;
        end else if (phase_wrap) begin
            phase_d = '0;
            flash_d = ~flash_q;
        end else begin
            phase_d = phase_q + PW'(1);
        end
    end

    always_comb begin
        int_d = int_q;
        if (press_i) begin
            case (int_q)
                INT_DOOR: int_d = INT_ON;
                INT_ON:   int_d = INT_OFF;
                default:  int_d = INT_DOOR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q   <= EXT_OFF;
            int_q   <= INT_DOOR;
            phase_q <= '0;
            flash_q <= 1'b0;
        end else begin
            ext_q   <= ext_d;
            int_q   <= int_d;
            phase_q <= phase_d;
            flash_q <= flash_d;
        end
    end

    assign select_ext = ext_select(ext_q);
    assign select_int = int_select(int_q);
    assign flash      = flash_q;

endmodule

// File: tb/tb_light_cmd_encoder.sv
// tb/tb_light_cmd_encoder.sv - randomized self-checking bench for light_cmd_encoder against a timing-level reference model
module tb_light_cmd_encoder;

    localparam int D  = 4;
    localparam int HP = 8;
    localparam int NC = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_hazard = 1'b0, btn_int = 1'b0;
    logic [0:1] select_ext, select_int;
    logic       flash;

    light_cmd_encoder #(
        .DEBOUNCE_CYCLES(D), .FLASH_HALF_PERIOD(HP), .AUTO_CANCEL_FLASHES(NC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_left(btn_left), .btn_right(btn_right), .btn_hazard(btn_hazard), .btn_int(btn_int),
        .select_ext(select_ext), .select_int(select_int), .flash(flash)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;

    // Model: ext 0=off 1=left 2=right 3=hazard; int 0=door 1=on 2=off.
    int m_ext, m_int, ef, se;
    int sched[4];
    bit in_reset;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic int exp_ext();
        case (m_ext)
            1:       return 2;
            2:       return 1;
            3:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_int();
        case (m_int)
            1:       return 0;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int exp_flash();
        if (m_ext == 0) return 0;
        return (((n - ef) / HP) % 2 == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_int = 0; ef = 0; se = 0;
        for (int b = 0; b < 4; b++) sched[b] = -1;
    endtask

    task automatic model_edge();
        bit p[4];
        int nxt;
        for (int b = 0; b < 4; b++) begin
            p[b] = (sched[b] == n);
            if (p[b]) sched[b] = -1;
        end
        nxt = m_ext;
        if (p[2])              nxt = (m_ext == 3) ? 0 : 3;
        else if (p[0] && !p[1]) nxt = (m_ext == 3) ? 3 : ((m_ext == 1) ? 0 : 1);
        else if (p[1] && !p[0]) nxt = (m_ext == 3) ? 3 : ((m_ext == 2) ? 0 : 2);
`ifdef LIGHT_CMD_AUTO_CANCEL_EN
        if (nxt == m_ext && (m_ext == 1 || m_ext == 2) && ((n - ef) % (2 * HP) == 0) &&
            ((n - ef) / (2 * HP) - (se - ef) / (2 * HP) == NC))
            nxt = 0;
`endif
        if (m_ext == 0 && nxt != 0) ef = n;
        if (nxt != m_ext) se = n;
        m_ext = nxt;
        if (p[3]) m_int = (m_int + 1) % 3;
    endtask

    task automatic check_outputs(input string when);
        check_val({when, ".select_ext"}, int'(select_ext), exp_ext());
        check_val({when, ".select_int"}, int'(select_int), exp_int());
        check_val({when, ".flash"}, int'(flash), exp_flash());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
        if (!in_reset) model_edge();
        check_outputs("cyc");
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_left   = v;
            1: btn_right  = v;
            2: btn_hazard = v;
            default: btn_int = v;
        endcase
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                set_btn(b, 1'b1);
                sched[b] = n + D + 3;
            end
        end
        idle(hold);
        for (int b = 0; b < 4; b++) set_btn(b, 1'b0);
        idle(D + 4 + int'($urandom_range(0, 6)));
    endtask

    task automatic glitch(input int b, input int g);
        set_btn(b, 1'b1);
        idle(g);
        set_btn(b, 1'b0);
        idle(D + 4);
    endtask

    task automatic bounce(input int b);
        for (int i = 0; i < 20; i++) begin
            set_btn(b, (i % 2 == 0) ? 1'b1 : 1'b0);
            step();
        end
        set_btn(b, 1'b0);
        idle(D + 4);
    endtask

    task automatic do_reset(input int held);
        if (held >= 0) set_btn(held, 1'b1);
        #1;
        rst_n    = 1'b0;
        in_reset = 1'b1;
        model_reset();
        #1;
        check_outputs("rst_async");
        idle(3);
        rst_n    = 1'b1;
        in_reset = 1'b0;
        if (held >= 0) sched[held] = n + D + 3;
        idle(D + 6);
        if (held >= 0) set_btn(held, 1'b0);
        idle(D + 4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        logic [3:0] mask;
        model_reset();
        in_reset = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_outputs("rst_init");
        idle(2);
        rst_n    = 1'b1;
        in_reset = 1'b0;

        bounce(0);
        press(4'b0001, 6);
        idle(20);
        press(4'b0100, D + 1);
        idle(13);
        press(4'b0100, D);
        press(4'b0011, D + 2);
        press(4'b1000, D);
        press(4'b1000, D);
        press(4'b1000, D);
        press(4'b0010, D);
        idle(500);
        press(4'b0100, D);
        idle(11);
        do_reset(-1);
        press(4'b0100, D);
        do_reset(0);

        for (int it = 0; it < 70; it++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 5) begin
                mask = 4'($urandom_range(1, 15));
                if ($urandom_range(0, 1) == 1) mask = 4'(1 << $urandom_range(0, 3));
                press(mask, D + int'($urandom_range(0, 3)));
            end else if (op == 6) begin
                glitch(int'($urandom_range(0, 3)), int'($urandom_range(1, D - 1)));
            end else if (op == 7) begin
                idle(int'($urandom_range(1, 40)));
            end else if (op == 8) begin
                do_reset(int'($urandom_range(0, 4)) - 1);
            end else begin
                bounce(int'($urandom_range(0, 3)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
